intersection_phase_scheduler: RTL
=================================

# intersection_phase_scheduler

Actuated phase scheduler for a two-approach signalised intersection. It sequences the green/yellow/red lamp outputs for approach 1 and approach 2 and arbitrates green time between them from vehicle detector inputs. It enforces minimum green, maximum green, gap-out extension, yellow and all-red clearance, and an optional pedestrian walk interval. The lamp outputs drive the signal-head LEDs directly.

## Interface
- MIN_GREEN, 10: minimum green duration in cycles.
- MAX_GREEN, 30: green limit in cycles while opposing demand exists.
- EXT, 3: gap-out threshold, in consecutive cycles with own detector low.
- YELLOW, 4: yellow duration in cycles.
- ALL_RED, 2: all-red clearance duration in cycles.
- WALK, 8: pedestrian walk duration in cycles.
- CW, 8: timer width; all durations must be ≤ 2^CW−1 and ≥1.

Ports:
- ck  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- det1  in  1  approach-1 vehicle detector, level, synchronous to ck.
- det2  in  1  approach-2 vehicle detector, level.
- ped_req  in  1  pedestrian button, ≥1-cycle pulse.
- g1, y1, r1  out  1 each  approach-1 lamps, 1 = on.
- g2, y2, r2  out  1 each  approach-2 lamps, 1 = on.
- walk  out  1  pedestrian walk lamp.
- phase  out  3  current state code: AR1=0, G1=1, Y1=2, AR2=3, G2=4, Y2=5, WK=6.

## Operation
- States:
  - AR1: all red, then G1.
  - G1, Y1: approach-1 green, then yellow.
  - AR2: all red, then G2.
  - G2, Y2: approach-2 green, then yellow.
  - WK: walk; all vehicle lamps red.
- Transition order: Y1→AR2 and Y2→AR1. WK is entered from AR1 or AR2 when ped_pend is set at AR expiry. After WK the controller goes to the other AR state, then to its green.
- Demand latches:
  - dem2 sets on det2=1 in any state except G2; it clears on entry to G2.
  - dem1 is symmetric.
  - ped_pend sets on ped_req in any state except WK; it clears on entry to WK.
- Green counters:
  - n counts green cycles, 1 on the first cycle, saturating at MAX_GREEN.
  - gap counts consecutive cycles with own detector low, saturating at EXT, cleared when the detector is high.
- Green exit condition: opposing demand or ped_pend is set, n ≥ MIN_GREEN, and either gap ≥ EXT (gap-out) or n = MAX_GREEN (max-out). The next state is yellow.
- Green rest: with no opposing demand and no ped_pend, green holds indefinitely. Max-out does not apply.
- Y, AR and WK states last exactly their parameter cycle counts. A down-counter is loaded with duration−1 and the state advances when it reaches 0.
- Lamps: exactly one of g/y/r is on per approach at all times. walk=1 only in WK.
- Reset: state = AR1 with the timer loaded. All latches and counters clear. r1=r2=1, all other outputs 0, phase=0. Outputs take these values asynchronously, including when reset is asserted mid-phase.

## Timing
- Lamp outputs and phase are registered. They change on the same rising edge as the state transition.
- First green after reset release: the g1 rising edge is ALL_RED cycles after the first ck edge with rst_n=1.
- A detector or ped_req edge is sampled on the next ck edge. A demand arriving on the edge where green exits counts as already latched.
- det high and ped_req high in the same cycle: both latches set. Walk is served before the opposing green.
- Simultaneous gap-out and max-out: take the same yellow transition, once.

## Configuration
- PED_WALK_EN defined: ped_req is latched, WK is reachable, and walk behaves as specified.
- PED_WALK_EN undefined: ped_req is ignored, ped_pend is constant 0, walk is tied 0, and the WK state logic is compiled out. Phase code 6 never appears.

## Test plan
- Reset with no demand: r1=r2=1 for 2 cycles after release, then g1=1 held for 100+ cycles, and phase stays 1.
- In G1, det1=0 throughout and a det2 pulse at green cycle 5: g1 lasts 10 cycles, y1 4, all-red 2, then g2=1 and dem2 clears.
- det1 held high and det2 pulsed at G1 cycle 2: max-out; g1 lasts 30 cycles, then y1=1.
- det1 high until G1 cycle 15, then low, with dem2 set: gap-out; y1=1 after G1 cycle 18.
- PED_WALK_EN defined, ped_req pulse in G1 with dem2 set: Y1 (4), AR2 (2), walk=1 with r1=r2=1 for 8 cycles, AR1 (2), then G2. Without PED_WALK_EN the same stimulus produces no walk, and g2 follows AR2.
- rst_n low mid-Y2: r1=r2=1 and all other outputs 0 immediately, without a ck edge; on release the controller restarts at AR1.

Source files
------------

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler
// Actuated phase scheduler for a two-approach intersection. Sequences the lamp outputs
// through AR1 -> G1 -> Y1 -> AR2 -> G2 -> Y2 -> AR1. Green time is arbitrated from the
// detector inputs: minimum green, gap-out, max-out and rest-in-green.
// Optional pedestrian walk interval: define PED_WALK_EN to enable the WK state. In the
// default build ped_req is ignored and walk is tied low.
module intersection_phase_scheduler #(
   parameter int unsigned MIN_GREEN = 10,
   parameter int unsigned MAX_GREEN = 30,
   parameter int unsigned EXT       = 3,
   parameter int unsigned YELLOW    = 4,
   parameter int unsigned ALL_RED   = 2,
   parameter int unsigned WALK      = 8,
   parameter int unsigned CW        = 8
) (
   input  logic       ck,
   input  logic       rst_n,
   input  logic       det1,
   input  logic       det2,
   input  logic       ped_req,
   output logic       g1,
   output logic       y1,
   output logic       r1,
   output logic       g2,
   output logic       y2,
   output logic       r2,
   output logic       walk,
   output logic [2:0] phase
);

   // Encodings double as the phase output code.
   typedef enum logic [2:0] {
      StAr1 = 3'd0,
      StG1  = 3'd1,
      StY1  = 3'd2,
      StAr2 = 3'd3,
      StG2  = 3'd4,
      StY2  = 3'd5
`ifdef PED_WALK_EN
      ,
      StWk  = 3'd6
`endif
   } state_e;

   localparam logic [CW-1:0] MinGreenC = CW'(MIN_GREEN);
   localparam logic [CW-1:0] MaxGreenC = CW'(MAX_GREEN);
   localparam logic [CW-1:0] ExtC      = CW'(EXT);
   localparam logic [CW-1:0] YellowLd  = CW'(YELLOW - 1);
   localparam logic [CW-1:0] AllRedLd  = CW'(ALL_RED - 1);
   // The reset state counts the first edge after release as its entry, so AR1 still
   // spans ALL_RED full cycles once the clock starts.
   localparam logic [CW-1:0] AllRedRst = CW'(ALL_RED);
`ifdef PED_WALK_EN
   localparam logic [CW-1:0] WalkLd    = CW'(WALK - 1);
`endif

   state_e        state_q, state_d;
   logic [CW-1:0] timer_q, timer_d;
   logic [CW-1:0] n_q, n_d;
   logic [CW-1:0] gap_q, gap_d;
   logic          dem1_q, dem1_d;
   logic          dem2_q, dem2_d;
`ifdef PED_WALK_EN
   logic          ped_q, ped_d;
   logic          tgt2_q, tgt2_d;      // green to serve after the current all-red
   logic          wk_from2_q, wk_from2_d;
   logic          in_wk;
   logic          walk_d;
`endif

   logic          in_g1, in_g2;
   logic          own_det;
   logic          dem1_eff, dem2_eff, ped_eff;
   logic          opp_dem;
   logic [CW-1:0] n_nxt, gap_nxt;
   logic          green_exit;
   logic          timer_done;
   logic [5:0]    lamp_d;             // {g1, y1, r1, g2, y2, r2}

   // Demand seen this edge, including a detector arriving on the edge itself.
   always_comb begin
      in_g1      = (state_q == StG1);
      in_g2      = (state_q == StG2);
      own_det    = in_g1 ? det1 : det2;
      dem1_eff   = dem1_q | (det1 & ~in_g1);
      dem2_eff   = dem2_q | (det2 & ~in_g2);
`ifdef PED_WALK_EN
      in_wk      = (state_q == StWk);
      ped_eff    = ped_q | (ped_req & ~in_wk);
`else
      ped_eff    = 1'b0;
`endif
      opp_dem    = in_g1 ? dem2_eff : dem1_eff;
      n_nxt      = (n_q >= MaxGreenC) ? MaxGreenC : n_q + 1'b1;
      gap_nxt    = own_det ? '0 : ((gap_q >= ExtC) ? ExtC : gap_q + 1'b1);
      // Gap uses the current cycle's detector; max-out uses the current green cycle.
      green_exit = (opp_dem | ped_eff) & (n_q >= MinGreenC) &
                   ((gap_nxt >= ExtC) | (n_q == MaxGreenC));
      timer_done = (timer_q == '0);
   end

   // Next-state, timer, green counters and demand latches.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      n_d        = n_q;
      gap_d      = gap_q;
      dem1_d     = dem1_eff;
      dem2_d     = dem2_eff;
`ifdef PED_WALK_EN
      ped_d      = ped_eff;
      tgt2_d     = tgt2_q;
      wk_from2_d = wk_from2_q;
`endif
      unique case (state_q)
         StAr1, StAr2: begin
            if (!timer_done) begin
               timer_d = timer_q - 1'b1;
`ifdef PED_WALK_EN
            end else if (ped_eff) begin
               state_d    = StWk;
               timer_d    = WalkLd;
               ped_d      = 1'b0;
               wk_from2_d = (state_q == StAr2);
            end else if (tgt2_q) begin
`else
            end else if (state_q == StAr2) begin
`endif
               state_d = StG2;
               n_d     = CW'(1);
               gap_d   = '0;
               dem2_d  = 1'b0;
            end else begin
               state_d = StG1;
               n_d     = CW'(1);
               gap_d   = '0;
               dem1_d  = 1'b0;
            end
         end
         StG1, StG2: begin
            if (green_exit) begin
               state_d = in_g1 ? StY1 : StY2;
               timer_d = YellowLd;
            end else begin
               n_d   = n_nxt;
               gap_d = gap_nxt;
            end
         end
         StY1: begin
            if (timer_done) begin
               state_d = StAr2;
               timer_d = AllRedLd;
`ifdef PED_WALK_EN
               tgt2_d  = 1'b1;
`endif
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         StY2: begin
            if (timer_done) begin
               state_d = StAr1;
               timer_d = AllRedLd;
`ifdef PED_WALK_EN
               tgt2_d  = 1'b0;
`endif
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
`ifdef PED_WALK_EN
         StWk: begin
            // Leave through the opposite all-red; the deferred green is kept in tgt2.
            if (timer_done) begin
               state_d = wk_from2_q ? StAr1 : StAr2;
               timer_d = AllRedLd;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
`endif
         default: begin
            state_d = StAr1;
            timer_d = AllRedLd;
         end
      endcase
   end

   // Lamp pattern for the state being entered, so lamps change with the transition.
   always_comb begin
      lamp_d = 6'b001_001;
      case (state_d)
         StG1:    lamp_d = 6'b100_001;
         StY1:    lamp_d = 6'b010_001;
         StG2:    lamp_d = 6'b001_100;
         StY2:    lamp_d = 6'b001_010;
         default: lamp_d = 6'b001_001;
      endcase
`ifdef PED_WALK_EN
      walk_d = (state_d == StWk);
`endif
   end

   // All state and registered outputs; reset forces the all-red pattern immediately.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state_q                  <= StAr1;
         timer_q                  <= AllRedRst;
         n_q                      <= '0;
         gap_q                    <= '0;
         dem1_q                   <= 1'b0;
         dem2_q                   <= 1'b0;
         {g1, y1, r1, g2, y2, r2} <= 6'b001_001;
         phase                    <= 3'd0;
`ifdef PED_WALK_EN
         ped_q                    <= 1'b0;
         tgt2_q                   <= 1'b0;
         wk_from2_q               <= 1'b0;
         walk                     <= 1'b0;
`endif
      end else begin
         state_q                  <= state_d;
         timer_q                  <= timer_d;
         n_q                      <= n_d;
         gap_q                    <= gap_d;
         dem1_q                   <= dem1_d;
         dem2_q                   <= dem2_d;
         {g1, y1, r1, g2, y2, r2} <= lamp_d;
         phase                    <= state_d;
`ifdef PED_WALK_EN
         ped_q                    <= ped_d;
         tgt2_q                   <= tgt2_d;
         wk_from2_q               <= wk_from2_d;
         walk                     <= walk_d;
`endif
      end
   end

`ifndef PED_WALK_EN
   logic          unused_ped_req;
   logic [CW-1:0] unused_walk_len;
   assign unused_ped_req  = ped_req;
   assign unused_walk_len = CW'(WALK);
   assign walk            = 1'b0;
`endif

endmodule
